// File: rtl/gups_pkg.sv
// Shared types and helpers for the GUPS RAW hazard guard.
// A line address is the byte address with the intra-line offset dropped.
package gups_pkg;

    localparam int DEFAULT_LINE_BITS = 6;

    typedef logic [63-DEFAULT_LINE_BITS:0] line_addr_t;

    function automatic logic [63:0] to_line(input logic [63:0] addr, input int unsigned line_bits);
        return addr >> line_bits;
    endfunction

endpackage

// File: rtl/gups_axi_bus.sv
// Minimal single-ID AXI bus used between the engine, the guard and memory.
// Modports are named for the agent on the far side: .master faces an engine, .slave faces memory.
interface axi_bus_t;
    import gups_pkg::*;

    logic        awvalid;
    logic        awready;
    logic [63:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [63:0] wdata;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    modport master (
        input  awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        output awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/gups_wtable.sv
// Circular table of line addresses with outstanding writes, retired in order by B.
// Lookup compares against every valid entry in parallel.
module gups_wtable
    import gups_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int LINE_W = 64 - DEFAULT_LINE_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [LINE_W-1:0] alloc_line,
    input  logic              free,
    input  logic [LINE_W-1:0] lookup_line,
    output logic              hit,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [LINE_W-1:0] lines [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count;
    logic              do_alloc;
    logic              do_free;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_alloc = alloc && !full;
    assign do_free  = free && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_alloc) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            // Entries are only freed when occupied, so the two indices never collide.
            if (do_free) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_alloc && !do_free) begin
                count <= count + 1'b1;
            end else if (do_free && !do_alloc) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            lines[wr_ptr] <= alloc_line;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (lines[i] == lookup_line)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gups_raw_guard.sv
// Holds back engine reads to lines with writes still in flight; W/R/B pass straight through.
// Hazard and full depend only on registered state and the engine read address.
module gups_raw_guard
    import gups_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LINE_BITS = DEFAULT_LINE_BITS,
    parameter int CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    axi_bus_t.master    eng,
    axi_bus_t.slave     mem,
    input  logic        clear,
    output logic [63:0] stall_cycles,
    output logic        err
);

    localparam int LINE_W = 64 - LINE_BITS;

    logic             full;
    logic             empty;
    logic             hit;
    logic             hazard;
    logic             aw_hs;
    logic             ar_hs;
    logic             b_hs;
    logic [CNT_W-1:0] aw_seq;
    logic [CNT_W-1:0] ar_seq;
    logic [CNT_W-1:0] seq_diff;

    assign mem.awvalid = eng.awvalid && !full;
    assign eng.awready = mem.awready && !full;
    assign mem.awaddr  = eng.awaddr;

    assign mem.arvalid = eng.arvalid && !hazard;
    assign eng.arready = mem.arready && !hazard;
    assign mem.araddr  = eng.araddr;

    assign mem.wvalid  = eng.wvalid;
    assign mem.wdata   = eng.wdata;
    assign mem.wlast   = eng.wlast;
    assign eng.wready  = mem.wready;

    assign eng.bvalid  = mem.bvalid;
    assign eng.bresp   = mem.bresp;
    assign mem.bready  = eng.bready;

    assign eng.rvalid  = mem.rvalid;
    assign eng.rdata   = mem.rdata;
    assign eng.rresp   = mem.rresp;
    assign eng.rlast   = mem.rlast;
    assign mem.rready  = eng.rready;

    assign aw_hs = mem.awvalid && mem.awready;
    assign ar_hs = mem.arvalid && mem.arready;
    assign b_hs  = mem.bvalid && mem.bready;

    // Equal counters mean this read's predecessor write has not been accepted yet.
    assign seq_diff = aw_seq - ar_seq;
    assign hazard   = hit || (seq_diff == '0);

    gups_wtable #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_wtable (
        .clk         (clk),
        .rst         (rst),
        .alloc       (aw_hs),
        .alloc_line  (LINE_W'(to_line(eng.awaddr, LINE_BITS))),
        .free        (b_hs),
        .lookup_line (LINE_W'(to_line(eng.araddr, LINE_BITS))),
        .hit         (hit),
        .full        (full),
        .empty       (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_seq       <= '0;
            ar_seq       <= '0;
            stall_cycles <= '0;
            err          <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_seq <= aw_seq + 1'b1;
            end
            if (ar_hs) begin
                ar_seq <= ar_seq + 1'b1;
            end
            if (clear) begin
                stall_cycles <= '0;
            end else if (eng.arvalid && hazard) begin
                stall_cycles <= stall_cycles + 64'd1;
            end
            if (b_hs && empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gups_raw_guard.sv
// Bench for gups_raw_guard: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of outstanding writes.
module tb_gups_raw_guard;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [63:0] stall_cycles;
    logic        err;

    axi_bus_t eng_if ();
    axi_bus_t mem_if ();

    gups_raw_guard #(.DEPTH(DEPTH), .LINE_BITS(6), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .eng          (eng_if),
        .mem          (mem_if),
        .clear        (clear),
        .stall_cycles (stall_cycles),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0]     q[$];
    longint unsigned aw_n;
    longint unsigned ar_n;
    longint unsigned m_stall;
    bit              m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a >> 6;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'(($urandom_range(0, 11) * 64) + $urandom_range(0, 63));
        return a;
    endfunction

    task automatic tick();
        bit haz;
        bit full_e;
        bit aw_hs;
        bit ar_hs;
        bit b_hs;
        logic [63:0] awa;
        eng_if.wvalid = 1'($urandom);
        eng_if.wdata  = {$urandom, $urandom};
        eng_if.wlast  = 1'($urandom);
        eng_if.rready = 1'($urandom);
        mem_if.wready = 1'($urandom);
        mem_if.rvalid = 1'($urandom);
        mem_if.rdata  = {$urandom, $urandom};
        mem_if.rresp  = 2'($urandom);
        mem_if.rlast  = 1'($urandom);
        mem_if.bresp  = 2'($urandom);
        #1;
        full_e = (q.size() == DEPTH);
        haz = (ar_n >= aw_n);
        foreach (q[i]) if (q[i] == line_of(eng_if.araddr)) haz = 1'b1;
        check("mem_awvalid", 64'(mem_if.awvalid), 64'(eng_if.awvalid && !full_e));
        check("eng_awready", 64'(eng_if.awready), 64'(mem_if.awready && !full_e));
        check("mem_arvalid", 64'(mem_if.arvalid), 64'(eng_if.arvalid && !haz));
        check("eng_arready", 64'(eng_if.arready), 64'(mem_if.arready && !haz));
        check("mem_awaddr", mem_if.awaddr, eng_if.awaddr);
        check("mem_araddr", mem_if.araddr, eng_if.araddr);
        check("w_pass", {mem_if.wdata[61:0], mem_if.wvalid, mem_if.wlast},
              {eng_if.wdata[61:0], eng_if.wvalid, eng_if.wlast});
        check("r_pass", {eng_if.rdata[59:0], eng_if.rvalid, eng_if.rlast, eng_if.rresp},
              {mem_if.rdata[59:0], mem_if.rvalid, mem_if.rlast, mem_if.rresp});
        check("b_pass", {60'd0, eng_if.bvalid, mem_if.bready, eng_if.bresp},
              {60'd0, mem_if.bvalid, eng_if.bready, mem_if.bresp});
        check("misc_ready", {62'd0, eng_if.wready, mem_if.rready}, {62'd0, mem_if.wready, eng_if.rready});
        check("stall_cycles", stall_cycles, m_stall);
        check("err", 64'(err), 64'(m_err));
        aw_hs = eng_if.awvalid && mem_if.awready && !full_e;
        ar_hs = eng_if.arvalid && mem_if.arready && !haz;
        b_hs  = mem_if.bvalid && eng_if.bready;
        awa   = eng_if.awaddr;
        if (clear) m_stall = 0;
        else if (eng_if.arvalid && haz) m_stall++;
        @(posedge clk);
        if (b_hs) begin
            if (q.size() == 0) m_err = 1'b1;
            else void'(q.pop_front());
        end
        if (aw_hs) begin
            q.push_back(line_of(awa));
            aw_n++;
        end
        if (ar_hs) ar_n++;
        @(negedge clk);
    endtask

    task automatic drive(input bit awv, input logic [63:0] awa, input bit arv, input logic [63:0] ara,
                         input bit awr, input bit arr, input bit bv, input bit br, input bit clr);
        eng_if.awvalid = awv;
        eng_if.awaddr  = awa;
        eng_if.arvalid = arv;
        eng_if.araddr  = ara;
        mem_if.awready = awr;
        mem_if.arready = arr;
        mem_if.bvalid  = bv;
        eng_if.bready  = br;
        clear          = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 1, 0, 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eng_if.awvalid = 0; eng_if.awaddr = 0; eng_if.arvalid = 0; eng_if.araddr = 0;
        eng_if.wvalid = 0; eng_if.wdata = 0; eng_if.wlast = 0; eng_if.bready = 0; eng_if.rready = 0;
        mem_if.awready = 0; mem_if.arready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bresp = 0;
        mem_if.rvalid = 0; mem_if.rdata = 0; mem_if.rresp = 0; mem_if.rlast = 0;
        clear = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        aw_n = 0; ar_n = 0; m_stall = 0; m_err = 1'b0;
    endtask

    task automatic rand_phase(input int cycles, input int pb);
        for (int i = 0; i < cycles; i++) begin
            drive(1'($urandom), rand_addr(), 1'($urandom), rand_addr(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  (q.size() != 0) && ($urandom_range(0, 99) < pb),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        do_reset();
        check("reset_stall", stall_cycles, 64'd0);
        check("reset_err", 64'(err), 64'd0);

        // Single update to 0x1000: read held until B returns, then one conservative cycle.
        drive(1, 64'h1000, 0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 64'h1010, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 64'h1000, 0, 1, 1, 1, 0);
        drive(0, 0, 1, 64'h1000, 0, 1, 0, 1, 0);
        check("single_stall_total", stall_cycles, 64'd4);
        drive(0, 0, 0, 0, 1, 1, 0, 1, 1);
        idle(1);

        // Read ahead of its predecessor write is held until that write is accepted.
        do_reset();
        drive(0, 0, 1, 64'h2000, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 64'h2000, 0, 1, 0, 1, 0);
        drive(1, 64'h5000, 1, 64'h2000, 1, 1, 0, 1, 0);
        drive(0, 0, 1, 64'h2000, 0, 1, 0, 1, 0);
        idle(1);

        // Fill the table, then AW together with B, then the retry.
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 64'(i * 64), 0, 0, 1, 1, 0, 1, 0);
        drive(1, 64'h800, 0, 0, 1, 1, 1, 1, 0);
        drive(1, 64'h800, 1, 64'h400, 1, 1, 0, 1, 0);
        drive(1, 64'h840, 0, 0, 1, 1, 0, 1, 0);
        idle(1);

        // Simultaneous alloc/free at half occupancy leaves the count unchanged.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, 64'(i * 64), 0, 0, 1, 1, 0, 1, 0);
        drive(1, 64'h2000, 0, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) drive(1, 64'(64'h4000 + i * 64), 0, 0, 1, 1, 0, 1, 0);
        drive(1, 64'h8000, 1, 64'h40, 1, 1, 1, 1, 0);
        idle(1);

        do_reset();
        rand_phase(800, 10);
        rand_phase(800, 60);

        // Stray B on an empty table: err sticks until reset.
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 1, 1, 0);
        idle(3);
        check("stray_err", 64'(err), 64'd1);
        do_reset();
        check("err_after_reset", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
